cam_array_seq: RTL and testbench
================================

Name: cam_array_seq

Overview:
- Parametrised successor to the associative cell array.
- An array of num_cells words, num_bits wide, with a per-cell tag register held inside the block (no longer driven externally).
- Executes one command at a time through a valid/ready command port and a valid/ready response port: masked search, masked parallel write to tagged cells, OR-read of tagged cells, and tag management including first-responder select.
- Sits between the sequencer/controller and the associative store; it is the single owner of cell contents and tags.

Parameters:
- num_bits, 32: word width of each cell and of key/mask/data buses.
- num_cells, 100: number of cells; legal range 1..1024.
- cnt_w, $clog2(num_cells+1): width of the responder count (7 at default).

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_op  input  3  opcode (see Behaviour).
- cmd_key  input  num_bits  search key / write data.
- cmd_mask  input  num_bits  bit-enable: 1 = bit participates.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts response.
- resp_data  output  num_bits  READ result; 0 for other ops.
- resp_some  output  1  at least one tag set after the op.
- resp_count  output  cnt_w  number of tags set after the op.
- tags_out  output  num_cells  current tag register (debug/observe).

Behaviour:
- Reset (RST=1 at a CLK edge): all store words 0, all tags 0, FSM to IDLE, cmd_ready=0 during reset, resp_valid=0, resp_data=0, resp_some=0, resp_count=0.
- Reset mid-command aborts that command. No store or tag update from the aborted command.
- FSM states:
  - IDLE: cmd_ready=1. A handshake (cmd_valid&&cmd_ready) registers op/key/mask and goes to EXEC.
  - EXEC: cmd_ready=0. Applies the op at the end of this cycle, registers the response fields and goes to RESP.
  - RESP: resp_valid=1, with fields stable until resp_valid&&resp_ready, then to IDLE.
- Throughput is one command per 3 cycles minimum. Command accepted at edge N; resp_valid high from cycle after edge N+1.
- cmd_ready is 0 in EXEC and RESP; cmd_valid there is ignored and not lost by the block (the source must hold it).
- Match rule: cell i matches iff ((store[i] ^ key) & mask) == 0. mask=0 matches every cell.
- Opcodes:
  - 0 NOP: no change.
  - 1 SEARCH: tags <= tags & match.
  - 2 SEARCH_SET: tags <= match.
  - 3 WRITE: for tagged cells, store[i] <= (store[i] & ~mask) | (key & mask). Tags unchanged.
  - 4 READ: resp_data <= OR over tagged i of (store[i] & mask). Tags unchanged.
  - 5 SELECT_FIRST: keep only the lowest-index set tag; with no tags set, no change.
  - 6 SET_ALL: all tags 1.
  - 7 CLEAR_ALL: all tags 0.
- resp_some and resp_count always reflect the tag state after the op, including for WRITE/READ/NOP.
- resp_count is the exact popcount, maximum num_cells, with no wrap. resp_data is 0 for ops other than READ.
- READ with no tags set gives resp_data=0. WRITE with no tags or mask=0 leaves the store unchanged.
- WRITE and search are never combined in one op. The search for a command uses store contents as they stood before that command.
- num_cells=1: SELECT_FIRST is the identity and count width is 1.

Test Plan:
- Reset, then CLEAR_ALL; WRITE is a no-op → READ mask=FFFFFFFF gives resp_data=0, resp_some=0, resp_count=0. Also check cmd_ready=1 one cycle after reset release.
- SET_ALL; WRITE key=000000A5 mask=000000FF → SEARCH_SET key=000000A5 mask=000000FF gives resp_count=num_cells. SEARCH_SET key=000000A4 gives resp_count=0, resp_some=0.
- Load cells 3,7,9 with 12345678 (via SELECT_FIRST-chained writes), others 0; SEARCH_SET key=12345678 mask=FFFFFFFF → resp_count=3, tags_out bits 3,7,9. SELECT_FIRST → count=1, only bit 3. READ mask=0000FFFF → resp_data=00005678.
- Masked write: cell 3 holds FFFF0000, tagged alone; WRITE key=00001234 mask=0000FF00 → READ mask=FFFFFFFF gives FFFF1200.
- Handshake: hold resp_ready=0 for 5 cycles → resp_valid and the fields are stable, cmd_ready=0 throughout, and a second cmd_valid is not accepted until a cycle after resp_ready=1.
- Assert RST during EXEC of WRITE key=FFFFFFFF → after reset, SET_ALL then READ gives resp_data=0 and resp_valid stayed 0 through reset.

Source files
------------

// File: rtl/cam_array_seq.sv
// Associative cell array with internal per-cell tags, driven one command at a time
// through valid/ready command and response ports (IDLE -> EXEC -> RESP).
module cam_array_seq #(
   parameter int num_bits  = 32,
   parameter int num_cells = 100,
   parameter int cnt_w     = $clog2(num_cells + 1)
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [2:0]           cmd_op,
   input  logic [num_bits-1:0]  cmd_key,
   input  logic [num_bits-1:0]  cmd_mask,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [num_bits-1:0]  resp_data,
   output logic                 resp_some,
   output logic [cnt_w-1:0]     resp_count,
   output logic [num_cells-1:0] tags_out
);

   localparam logic [2:0] OP_NOP        = 3'd0;
   localparam logic [2:0] OP_SEARCH     = 3'd1;
   localparam logic [2:0] OP_SEARCH_SET = 3'd2;
   localparam logic [2:0] OP_WRITE      = 3'd3;
   localparam logic [2:0] OP_READ       = 3'd4;
   localparam logic [2:0] OP_SEL_FIRST  = 3'd5;
   localparam logic [2:0] OP_SET_ALL    = 3'd6;
   localparam logic [2:0] OP_CLEAR_ALL  = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [num_bits-1:0]  store [num_cells];
   logic [num_cells-1:0] tags_q;

   logic [2:0]           op_p0;
   logic [num_bits-1:0]  key_p0;
   logic [num_bits-1:0]  mask_p0;

   logic [num_cells-1:0] match;
   logic [num_cells-1:0] first_tag;
   logic [num_cells-1:0] tags_nxt;
   logic [num_bits-1:0]  rd_or;
   logic                 cmd_fire;

   function automatic logic [cnt_w-1:0] popcount(input logic [num_cells-1:0] v);
      logic [cnt_w-1:0] c;
      c = '0;
      for (int i = 0; i < num_cells; i++)
         c = c + cnt_w'(v[i]);
      return c;
   endfunction

   // ---- control FSM ----
   always_ff @(posedge CLK) begin
      if (RST) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      cmd_ready  = 1'b0;
      resp_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cmd_ready = !RST;
            if (cmd_valid && !RST) state_d = ST_EXEC;
         end
         ST_EXEC: state_d = ST_RESP;
         ST_RESP: begin
            resp_valid = !RST;
            if (resp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign cmd_fire = cmd_valid && cmd_ready;

   // ---- stage p0: command capture ----
   always_ff @(posedge CLK) begin
      if (cmd_fire) begin
         op_p0   <= cmd_op;
         key_p0  <= cmd_key;
         mask_p0 <= cmd_mask;
      end
   end

   // ---- EXEC: match, tag update and read reduction from pre-command store ----
   always_comb begin
      match = '0;
      rd_or = '0;
      for (int i = 0; i < num_cells; i++) begin
         match[i] = ((store[i] ^ key_p0) & mask_p0) == '0;
         if (tags_q[i]) rd_or = rd_or | (store[i] & mask_p0);
      end
   end

   // Isolates the lowest set bit; all-zero tags stay all-zero.
   assign first_tag = tags_q & (~tags_q + num_cells'(1));

   always_comb begin
      tags_nxt = tags_q;
      case (op_p0)
         OP_SEARCH:     tags_nxt = tags_q & match;
         OP_SEARCH_SET: tags_nxt = match;
         OP_SEL_FIRST:  tags_nxt = first_tag;
         OP_SET_ALL:    tags_nxt = '1;
         OP_CLEAR_ALL:  tags_nxt = '0;
         default:       tags_nxt = tags_q;
      endcase
   end

   // ---- stage p1: store/tag commit and response registers ----
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < num_cells; i++) store[i] <= '0;
         tags_q     <= '0;
         resp_data  <= '0;
         resp_some  <= 1'b0;
         resp_count <= '0;
      end else if (state_q == ST_EXEC) begin
         if (op_p0 == OP_WRITE) begin
            for (int i = 0; i < num_cells; i++)
               if (tags_q[i]) store[i] <= (store[i] & ~mask_p0) | (key_p0 & mask_p0);
         end
         tags_q     <= tags_nxt;
         resp_data  <= (op_p0 == OP_READ) ? rd_or : '0;
         resp_some  <= |tags_nxt;
         resp_count <= popcount(tags_nxt);
      end
   end

   assign tags_out = tags_q;

endmodule

// File: tb/tb_cam_array_seq.sv
// Self-checking bench for cam_array_seq: directed scenarios plus random commands
// compared against an array-based behavioural model.
module tb_cam_array_seq;

   localparam int NB = 32;
   localparam int NC = 100;
   localparam int CW = $clog2(NC + 1);

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [2:0]    cmd_op = 3'd0;
   logic [NB-1:0] cmd_key = '0;
   logic [NB-1:0] cmd_mask = '0;
   logic          resp_valid;
   logic          resp_ready = 1'b0;
   logic [NB-1:0] resp_data;
   logic          resp_some;
   logic [CW-1:0] resp_count;
   logic [NC-1:0] tags_out;

   cam_array_seq #(.num_bits(NB), .num_cells(NC)) dut (
      .CLK(CLK), .RST(RST),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_key(cmd_key), .cmd_mask(cmd_mask),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_some(resp_some), .resp_count(resp_count), .tags_out(tags_out)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // behavioural model
   bit [NB-1:0]   ms [NC];
   bit            mt [NC];
   logic [NB-1:0] exp_data;
   int            exp_count;
   logic [NC-1:0] exp_tags;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < NC; i++) begin ms[i] = '0; mt[i] = 1'b0; end
   endfunction

   function automatic void model_apply(input logic [2:0] op, input logic [NB-1:0] key,
                                       input logic [NB-1:0] mask);
      bit found;
      exp_data = '0;
      case (op)
         3'd1: for (int i = 0; i < NC; i++) mt[i] = mt[i] && (((ms[i] ^ key) & mask) == 0);
         3'd2: for (int i = 0; i < NC; i++) mt[i] = (((ms[i] ^ key) & mask) == 0);
         3'd3: for (int i = 0; i < NC; i++) if (mt[i]) ms[i] = (ms[i] & ~mask) | (key & mask);
         3'd4: for (int i = 0; i < NC; i++) if (mt[i]) exp_data = exp_data | (ms[i] & mask);
         3'd5: begin
            found = 1'b0;
            for (int i = 0; i < NC; i++)
               if (mt[i]) begin
                  if (found) mt[i] = 1'b0;
                  found = 1'b1;
               end
         end
         3'd6: for (int i = 0; i < NC; i++) mt[i] = 1'b1;
         3'd7: for (int i = 0; i < NC; i++) mt[i] = 1'b0;
         default: ;
      endcase
      exp_count = 0;
      for (int i = 0; i < NC; i++) begin
         exp_count += int'(mt[i]);
         exp_tags[i] = mt[i];
      end
   endfunction

   task automatic send(input logic [2:0] op, input logic [NB-1:0] key, input logic [NB-1:0] mask);
      int n;
      @(negedge CLK);
      cmd_op = op; cmd_key = key; cmd_mask = mask; cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 50) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 50) chk("cmd_ready_timeout", 1, 0);
      @(posedge CLK);
      #1 cmd_valid = 1'b0;
      model_apply(op, key, mask);
   endtask

   task automatic recv(input string tag);
      int lat;
      lat = 0;
      do begin
         @(negedge CLK);
         lat++;
      end while (!resp_valid && lat < 20);
      chk({tag, "_latency"}, lat, 2);
      chk({tag, "_data"}, resp_data, exp_data);
      chk({tag, "_count"}, resp_count, exp_count);
      chk({tag, "_some"}, resp_some, exp_count > 0);
      chk({tag, "_tags"}, tags_out, exp_tags);
      resp_ready = 1'b1;
      @(posedge CLK);
      #1 resp_ready = 1'b0;
   endtask

   task automatic cmd(input string tag, input logic [2:0] op, input logic [NB-1:0] key,
                      input logic [NB-1:0] mask);
      send(op, key, mask);
      recv(tag);
   endtask

   initial begin
      logic [NB-1:0] hold_data;
      logic [NB-1:0] rkey, rmask;
      logic [NC-1:0] t379;
      model_reset();

      // reset and first-cycle outputs
      repeat (3) @(negedge CLK);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      RST = 1'b0;
      @(negedge CLK);
      chk("post_rst_cmd_ready", cmd_ready, 1);
      chk("post_rst_resp_data", resp_data, 0);
      chk("post_rst_count", resp_count, 0);
      chk("post_rst_some", resp_some, 0);
      chk("post_rst_tags", tags_out, 0);

      // no tags: write is a no-op
      cmd("clr", 3'd7, 0, 0);
      cmd("wr_notag", 3'd3, 32'hDEADBEEF, 32'hFFFFFFFF);
      cmd("rd_empty", 3'd4, 0, 32'hFFFFFFFF);
      chk("rd_empty_const", resp_data, 0);

      // broadcast write then search
      cmd("setall", 3'd6, 0, 0);
      cmd("wr_a5", 3'd3, 32'h000000A5, 32'h000000FF);
      cmd("ss_a5", 3'd2, 32'h000000A5, 32'h000000FF);
      chk("ss_a5_full", resp_count, NC);
      cmd("ss_a4", 3'd2, 32'h000000A4, 32'h000000FF);
      chk("ss_a4_zero", resp_count, 0);

      // load cells 3,7,9 through SELECT_FIRST chaining
      cmd("setall2", 3'd6, 0, 0);
      cmd("wr_zero", 3'd3, 0, 32'hFFFFFFFF);
      for (int i = 0; i < 10; i++) begin
         cmd("chain_ss", 3'd2, 0, 32'hFFFFFFFF);
         cmd("chain_sf", 3'd5, 0, 0);
         cmd("chain_wr", 3'd3, (i == 3 || i == 7 || i == 9) ? 32'h12345678 : (32'h80000000 | i),
             32'hFFFFFFFF);
      end
      cmd("unmark_ss", 3'd2, 32'h80000000, 32'h80000000);
      cmd("unmark_wr", 3'd3, 0, 32'hFFFFFFFF);
      cmd("ss_379", 3'd2, 32'h12345678, 32'hFFFFFFFF);
      t379 = '0; t379[3] = 1'b1; t379[7] = 1'b1; t379[9] = 1'b1;
      chk("ss_379_count", resp_count, 3);
      chk("ss_379_tags", tags_out, t379);
      cmd("sf_3", 3'd5, 0, 0);
      chk("sf_3_count", resp_count, 1);
      chk("sf_3_tags", tags_out, 100'd8);
      cmd("rd_5678", 3'd4, 0, 32'h0000FFFF);
      chk("rd_5678_const", resp_data, 32'h00005678);

      // masked write on cell 3
      cmd("wr_ffff", 3'd3, 32'hFFFF0000, 32'hFFFFFFFF);
      cmd("wr_mask", 3'd3, 32'h00001234, 32'h0000FF00);
      cmd("rd_mask", 3'd4, 0, 32'hFFFFFFFF);
      chk("rd_mask_const", resp_data, 32'hFFFF1200);

      // backpressure: response held, second command waits
      send(3'd4, 0, 32'hFFFFFFFF);
      cmd_op = 3'd0; cmd_key = 0; cmd_mask = 0; cmd_valid = 1'b1;
      @(negedge CLK);
      chk("bp_exec_valid", resp_valid, 0);
      @(negedge CLK);
      hold_data = resp_data;
      for (int k = 0; k < 5; k++) begin
         chk("bp_valid", resp_valid, 1);
         chk("bp_ready_low", cmd_ready, 0);
         chk("bp_data", resp_data, exp_data);
         chk("bp_stable", resp_data, hold_data);
         chk("bp_count", resp_count, exp_count);
         @(negedge CLK);
      end
      resp_ready = 1'b1;
      @(posedge CLK);
      #1 resp_ready = 1'b0;
      @(negedge CLK);
      chk("bp_after_ready", cmd_ready, 1);
      chk("bp_after_valid", resp_valid, 0);
      @(posedge CLK);
      #1 cmd_valid = 1'b0;
      model_apply(3'd0, 0, 0);
      recv("bp_nop");

      // reset in the middle of a WRITE
      cmd("abort_setall", 3'd6, 0, 0);
      @(negedge CLK);
      cmd_op = 3'd3; cmd_key = 32'hFFFFFFFF; cmd_mask = 32'hFFFFFFFF; cmd_valid = 1'b1;
      @(posedge CLK);
      #1 cmd_valid = 1'b0;
      RST = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         chk("abort_resp_valid", resp_valid, 0);
         chk("abort_cmd_ready", cmd_ready, 0);
      end
      RST = 1'b0;
      model_reset();
      cmd("abort_set", 3'd6, 0, 0);
      cmd("abort_rd", 3'd4, 0, 32'hFFFFFFFF);
      chk("abort_rd_const", resp_data, 0);

      // random commands against the model
      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 3))
            0: rkey = 32'h0;
            1: rkey = 32'h12345678;
            2: rkey = $urandom_range(0, 3);
            default: rkey = $urandom;
         endcase
         case ($urandom_range(0, 3))
            0: rmask = 32'hFFFFFFFF;
            1: rmask = 32'h0000000F;
            2: rmask = 32'h0;
            default: rmask = $urandom;
         endcase
         cmd("rand", 3'($urandom_range(0, 7)), rkey, rmask);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
